// File: rtl/hart_seq.sv
// hart_seq: single-issue instruction sequencer for a simple hart.
// It steps through FETCH -> DECODE -> EXEC -> WB, and from WB either goes
// back to FETCH or stops in HALTED.
// It holds the program counter, the instruction register, the cycle counter
// and the retired-instruction counter.
// Optional feature: define HART_SEQ_TRAP_EN to trap on a misaligned
// next-PC instead of silently clearing the low two bits.
// All outputs are registered. Each output register is loaded from the
// next-state value, so it lines up with the state it decodes.
module hart_seq #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
  parameter int              CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic             instr_valid,
  input  logic             ex_done,
  input  logic             je,
  input  logic [XLEN-1:0]  jmp,
  input  logic             be,
  input  logic [XLEN-1:0]  br_off,
  input  logic             halt,
  output logic             w_enable,
  output logic [XLEN-1:0]  pc,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
  output logic             halted,
  output logic             trap
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALTED = 3'd5
  } state_t;

  localparam logic [XLEN-1:0]  PC_STEP    = {{(XLEN-3){1'b0}}, 3'd4};
  localparam logic [XLEN-1:0]  ADDR_ZERO  = {XLEN{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};

  // Next-PC selection. An absolute jump beats a relative branch, and a
  // relative branch beats sequential flow. All adds wrap modulo 2^XLEN.
  function automatic logic [XLEN-1:0] next_pc_f(
    input logic [XLEN-1:0] cur_pc,
    input logic            jump_en,
    input logic [XLEN-1:0] jump_tgt,
    input logic            br_en,
    input logic [XLEN-1:0] br_delta
  );
    logic [XLEN-1:0] res;
    if (jump_en) begin
      res = jump_tgt;
    end else if (br_en) begin
      res = cur_pc + br_delta;
    end else begin
      res = cur_pc + PC_STEP;
    end
    return res;
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  logic [XLEN-1:0]  pc_r;
  logic [XLEN-1:0]  pc_nxt_s;
  logic [XLEN-1:0]  target_s;
  logic [31:0]      instr_r;
  logic [31:0]      instr_nxt_s;
  logic             retire_s;
  logic [CNT_W-1:0] cycle_cnt_r;
  logic [CNT_W-1:0] instret_cnt_r;
  logic             imem_req_r;
  logic [XLEN-1:0]  imem_addr_r;
  logic             instr_valid_r;
  logic             w_enable_r;
  logic             halted_r;

`ifdef HART_SEQ_TRAP_EN
  logic             trap_r;
  logic             trap_nxt_s;
`else
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
`endif

  assign target_s = next_pc_f(pc_r, je, jmp, be, br_off);

  // Next-state, next-PC and instruction-capture logic.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    instr_nxt_s = instr_r;
    retire_s    = 1'b0;
`ifdef HART_SEQ_TRAP_EN
    trap_nxt_s  = trap_r;
`endif
    case (state_r)
      IDLE: begin
        state_nxt_s = FETCH;
      end
      FETCH: begin
        if (imem_ready) begin
          instr_nxt_s = imem_rdata;
          state_nxt_s = DECODE;
        end else begin
          state_nxt_s = FETCH;
        end
      end
      DECODE: begin
        state_nxt_s = EXEC;
      end
      EXEC: begin
        // The instruction counts as retired on entry to WB. The new count
        // is then visible during the same cycle as the w_enable strobe.
        if (ex_done) begin
          state_nxt_s = WB;
          retire_s    = 1'b1;
        end else begin
          state_nxt_s = EXEC;
        end
      end
      WB: begin
`ifdef HART_SEQ_TRAP_EN
        if (target_s[1:0] != 2'b00) begin
          trap_nxt_s  = 1'b1;
          state_nxt_s = HALTED;
        end else begin
          pc_nxt_s = target_s;
          if (halt) begin
            state_nxt_s = HALTED;
          end else begin
            state_nxt_s = FETCH;
          end
        end
`else
        pc_nxt_s = target_s & ALIGN_MASK;
        if (halt) begin
          state_nxt_s = HALTED;
        end else begin
          state_nxt_s = FETCH;
        end
`endif
      end
      HALTED: begin
        state_nxt_s = HALTED;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, program counter and instruction register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      pc_r    <= RESET_PC;
      instr_r <= 32'h0000_0000;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      instr_r <= instr_nxt_s;
    end
  end

  // Free-running cycle counter (frozen in HALTED) and retired-instruction counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt_r   <= CNT_ZERO;
      instret_cnt_r <= CNT_ZERO;
    end else begin
      if (state_r != HALTED) begin
        cycle_cnt_r <= cycle_cnt_r + CNT_ONE;
      end else begin
        cycle_cnt_r <= cycle_cnt_r;
      end
      if (retire_s) begin
        instret_cnt_r <= instret_cnt_r + CNT_ONE;
      end else begin
        instret_cnt_r <= instret_cnt_r;
      end
    end
  end

  // Registered outputs, decoded from the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      imem_req_r    <= 1'b0;
      imem_addr_r   <= ADDR_ZERO;
      instr_valid_r <= 1'b0;
      w_enable_r    <= 1'b0;
      halted_r      <= 1'b0;
    end else begin
      imem_req_r    <= (state_nxt_s == FETCH);
      imem_addr_r   <= (state_nxt_s == FETCH) ? pc_nxt_s : ADDR_ZERO;
      instr_valid_r <= (state_nxt_s == DECODE);
      w_enable_r    <= (state_nxt_s == WB);
      halted_r      <= (state_nxt_s == HALTED);
    end
  end

`ifdef HART_SEQ_TRAP_EN
  // Sticky misaligned-target trap flag; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trap_r <= 1'b0;
    end else begin
      trap_r <= trap_nxt_s;
    end
  end

  assign trap = trap_r;
`else
  assign trap = 1'b0;
`endif

  assign imem_req    = imem_req_r;
  assign imem_addr   = imem_addr_r;
  assign instr       = instr_r;
  assign instr_valid = instr_valid_r;
  assign w_enable    = w_enable_r;
  assign pc          = pc_r;
  assign cycle_cnt   = cycle_cnt_r;
  assign instret_cnt = instret_cnt_r;
  assign halted      = halted_r;

endmodule

// File: tb/tb_hart_seq.sv
// tb_hart_seq: directed self-checking bench for hart_seq.
// It uses hand-computed expected values for sequential flow, fetch stalls,
// jump/branch priority, PC wrap, the misaligned target, reset in the
// middle of an instruction, and halt.
module tb_hart_seq;

  localparam int XLEN  = 32;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             imem_req;
  logic [XLEN-1:0]  imem_addr;
  logic             imem_ready;
  logic [31:0]      imem_rdata;
  logic [31:0]      instr;
  logic             instr_valid;
  logic             ex_done;
  logic             je;
  logic [XLEN-1:0]  jmp;
  logic             be;
  logic [XLEN-1:0]  br_off;
  logic             halt;
  logic             w_enable;
  logic [XLEN-1:0]  pc;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;
  logic             halted;
  logic             trap;

  int checks = 0;
  int errors = 0;
  int edges  = 0;

  hart_seq #(
    .XLEN    (XLEN),
    .RESET_PC(32'h0000_0000),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .ex_done    (ex_done),
    .je         (je),
    .jmp        (jmp),
    .be         (be),
    .br_off     (br_off),
    .halt       (halt),
    .w_enable   (w_enable),
    .pc         (pc),
    .cycle_cnt  (cycle_cnt),
    .instret_cnt(instret_cnt),
    .halted     (halted),
    .trap       (trap)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle 1 ns past it before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic clear_ctl();
    je     = 1'b0;
    jmp    = 32'h0000_0000;
    be     = 1'b0;
    br_off = 32'h0000_0000;
    halt   = 1'b0;
  endtask

  // From the cycle just after FETCH is entered, advance into WB.
  // Garbage control inputs are held outside WB; they must be ignored.
  task automatic to_wb();
    je     = 1'b1;
    jmp    = 32'h0000_0BAC;
    be     = 1'b1;
    br_off = 32'h0000_0100;
    halt   = 1'b1;
    step();
    step();
    step();
    clear_ctl();
    check_eq("wb_wen", {63'd0, w_enable}, 64'd1);
  endtask

  int ph;

  initial begin
    rst        = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = 32'h0000_0000;
    ex_done    = 1'b0;
    clear_ctl();

    // Reset state.
    step(); step(); step();
    check_eq("rst_pc",      pc,          64'h0);
    check_eq("rst_cycle",   cycle_cnt,   64'h0);
    check_eq("rst_instret", instret_cnt, 64'h0);
    check_eq("rst_req",     {63'd0, imem_req},    64'h0);
    check_eq("rst_addr",    imem_addr,   64'h0);
    check_eq("rst_instr",   instr,       64'h0);
    check_eq("rst_halted",  {63'd0, halted},      64'h0);
    check_eq("rst_trap",    {63'd0, trap},        64'h0);

    // Back-to-back instructions: FETCH/DECODE/EXEC/WB, 4 cycles each.
    imem_ready = 1'b1;
    ex_done    = 1'b1;
    imem_rdata = 32'hA5A5_0001;
    rst        = 1'b1;
    edges      = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      ph = (k - 1) % 4;
      check_eq("seq_req",     {63'd0, imem_req},    (ph == 0) ? 64'd1 : 64'd0);
      check_eq("seq_addr",    imem_addr,   (ph == 0) ? 64'(4 * ((k - 1) / 4)) : 64'd0);
      check_eq("seq_ivalid",  {63'd0, instr_valid}, (ph == 1) ? 64'd1 : 64'd0);
      check_eq("seq_wen",     {63'd0, w_enable},    (ph == 3) ? 64'd1 : 64'd0);
      check_eq("seq_cycle",   cycle_cnt,   64'(k));
      check_eq("seq_instret", instret_cnt, 64'(k / 4));
      check_eq("seq_pc",      pc,          64'(4 * ((k - 1) / 4)));
    end
    check_eq("seq_instr", instr, 64'hA5A5_0001);

    // Fetch stall: ready low for 5 cycles in FETCH at pc 0xC.
    imem_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq("stall_req",     {63'd0, imem_req}, 64'd1);
      check_eq("stall_addr",    imem_addr,   64'h0C);
      check_eq("stall_instret", instret_cnt, 64'd3);
      check_eq("stall_cycle",   cycle_cnt,   64'(edges));
    end
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    check_eq("dec_instr",  instr, 64'hDEAD_BEEF);
    check_eq("dec_ivalid", {63'd0, instr_valid}, 64'd1);
    check_eq("dec_req",    {63'd0, imem_req},    64'd0);
    ex_done = 1'b0;
    step();
    step();
    check_eq("exec_wait_wen",     {63'd0, w_enable}, 64'd0);
    check_eq("exec_wait_instret", instret_cnt, 64'd3);
    ex_done = 1'b1;
    step();
    check_eq("exec_done_wen",     {63'd0, w_enable}, 64'd1);
    check_eq("exec_done_instret", instret_cnt, 64'd4);
    je  = 1'b1;
    jmp = 32'h0000_0100;
    step();
    clear_ctl();
    check_eq("jmp_addr", imem_addr, 64'h100);
    check_eq("jmp_pc",   pc,        64'h100);

    // je and be together: the jump wins.
    to_wb();
    check_eq("prio_pc_before", pc, 64'h100);
    je = 1'b1; jmp = 32'h0000_0040; be = 1'b1; br_off = 32'hFFFF_FFF8;
    step();
    clear_ctl();
    check_eq("prio_addr", imem_addr, 64'h40);

    // Sequential flow wraps at 2^XLEN.
    to_wb();
    je = 1'b1; jmp = 32'hFFFF_FFFC;
    step();
    clear_ctl();
    check_eq("top_addr", imem_addr, 64'hFFFF_FFFC);
    to_wb();
    step();
    check_eq("wrap_addr", imem_addr, 64'h0);
    check_eq("wrap_pc",   pc,        64'h0);

    // Relative branch alone.
    to_wb();
    be = 1'b1; br_off = 32'h0000_0010;
    step();
    clear_ctl();
    check_eq("br_addr", imem_addr, 64'h10);

    // Misaligned branch target.
    to_wb();
    check_eq("mis_pc_before", pc, 64'h10);
    be = 1'b1; br_off = 32'h0000_0006;
    step();
    clear_ctl();
`ifdef HART_SEQ_TRAP_EN
    check_eq("mis_trap",   {63'd0, trap},   64'd1);
    check_eq("mis_halted", {63'd0, halted}, 64'd1);
    check_eq("mis_pc",     pc,              64'h10);
    check_eq("mis_req",    {63'd0, imem_req}, 64'd0);
`else
    check_eq("mis_addr",   imem_addr,       64'h14);
    check_eq("mis_trap",   {63'd0, trap},   64'd0);
    check_eq("mis_halted", {63'd0, halted}, 64'd0);
`endif

    // Reset asserted mid-EXEC at pc 0x20.
    rst = 1'b0;
    step();
    rst   = 1'b1;
    edges = 0;
    step();
    check_eq("r2_addr", imem_addr, 64'h0);
    to_wb();
    je = 1'b1; jmp = 32'h0000_0020;
    step();
    clear_ctl();
    check_eq("r2_jmp_addr", imem_addr, 64'h20);
    step();
    step();
    check_eq("r2_exec_pc",      pc,          64'h20);
    check_eq("r2_exec_cycle",   cycle_cnt,   64'(edges));
    check_eq("r2_exec_instret", instret_cnt, 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("async_pc",      pc,          64'h0);
    check_eq("async_cycle",   cycle_cnt,   64'h0);
    check_eq("async_instret", instret_cnt, 64'h0);
    check_eq("async_req",     {63'd0, imem_req}, 64'd0);
    check_eq("async_wen",     {63'd0, w_enable}, 64'd0);
    step();
    step();
    check_eq("held_wen",   {63'd0, w_enable}, 64'd0);
    check_eq("held_cycle", cycle_cnt, 64'h0);

    // Halt in WB: pc still advances, then everything freezes.
    rst   = 1'b1;
    edges = 0;
    step();
    to_wb();
    halt = 1'b1;
    step();
    clear_ctl();
    check_eq("halt_halted",  {63'd0, halted}, 64'd1);
    check_eq("halt_pc",      pc,          64'h4);
    check_eq("halt_cycle",   cycle_cnt,   64'd5);
    check_eq("halt_instret", instret_cnt, 64'd1);
    check_eq("halt_req",     {63'd0, imem_req}, 64'd0);
    step(); step(); step();
    check_eq("frz_cycle",   cycle_cnt,   64'd5);
    check_eq("frz_instret", instret_cnt, 64'd1);
    check_eq("frz_halted",  {63'd0, halted},   64'd1);
    check_eq("frz_wen",     {63'd0, w_enable}, 64'd0);
    check_eq("frz_req",     {63'd0, imem_req}, 64'd0);
    check_eq("frz_pc",      pc,          64'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/hart_seq.md
HART_SEQ -- requirements
Module: hart_seq

Interface
REQ-001 Param XLEN, 32, address/data width of PC and jump operands (legal: 32, 64).
REQ-002 Param RESET_PC, 0, PC value loaded at reset.
REQ-003 Param CNT_W, 32, width of cycle and retired-instruction counters.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 imem_req  out  1  fetch request, held high while in FETCH.
REQ-007 imem_addr  out  XLEN  fetch address, equal to pc while imem_req high, else 0.
REQ-008 imem_ready  in  1  memory handshake; data valid when high during imem_req.
REQ-009 imem_rdata  in  32  fetched instruction.
REQ-010 instr  out  32  instruction register, stable from DECODE through WB.
REQ-011 instr_valid  out  1  one-cycle pulse in DECODE.
REQ-012 ex_done  in  1  execute path completion, sampled only in EXEC.
REQ-013 je  in  1  absolute jump enable; target jmp.
REQ-014 jmp  in  XLEN  absolute jump target.
REQ-015 be  in  1  relative branch taken; target pc + br_off.
REQ-016 br_off  in  XLEN  signed branch offset.
REQ-017 halt  in  1  stop request, sampled in WB.
REQ-018 w_enable  out  1  register-file write strobe, one cycle in WB.
REQ-019 pc  out  XLEN  current program counter.
REQ-020 cycle_cnt  out  CNT_W  cycles since reset release.
REQ-021 instret_cnt  out  CNT_W  retired instructions.
REQ-022 halted  out  1  high in HALTED state.
REQ-023 trap  out  1  misaligned-target trap flag (only with TRAP_EN; else tied 0).

Function
REQ-024 FSM states SHALL be IDLE, FETCH, DECODE, EXEC, WB, HALTED.
REQ-025 IDLE -> FETCH on first clock edge after reset release.
REQ-026 FETCH: imem_req high; on imem_ready high, instr <= imem_rdata, go DECODE; otherwise stay, no limit on wait.
REQ-027 DECODE: instr_valid high for exactly one cycle; go EXEC next edge.
REQ-028 EXEC: stay until ex_done high; then go WB; ex_done outside EXEC ignored.
REQ-029 WB: w_enable high one cycle; instret_cnt +1; pc updated at WB exit.
REQ-030 PC update priority: je -> jmp; else be -> pc + br_off (XLEN modulo add); else pc + 4 (wraps at 2^XLEN).
REQ-031 je and be both high in WB: je wins.
REQ-032 WB exit: halt high -> HALTED (pc still updated); else FETCH.
REQ-033 HALTED: absorbing; only reset exits; no requests, no strobes, counters frozen.
REQ-034 cycle_cnt increments every cycle outside reset and HALTED; wraps at 2^CNT_W.
REQ-035 instret_cnt wraps at 2^CNT_W; incremented only in WB.
REQ-036 je/be/halt/jmp/br_off ignored outside WB.
REQ-037 Minimum instruction latency: 4 cycles (FETCH with ready, DECODE, EXEC with ex_done, WB).

Reset
REQ-038 rst low asynchronously forces: state IDLE, pc RESET_PC, instr 0, all counters 0, all outputs 0.
REQ-039 Reset mid-instruction (any state) abandons it; no w_enable, no counter increment.

Configuration
REQ-040 Macro HART_SEQ_TRAP_EN defined: if selected next PC has bits [1:0] != 0 in WB, w_enable still asserts, pc keeps old value, trap set sticky, go HALTED.
REQ-041 HART_SEQ_TRAP_EN undefined: next PC bits [1:0] forced to 0, no trap, trap output tied 0.

Verification
REQ-042 Reset release, imem_ready=1, ex_done=1, no je/be -> imem_addr 0,4,8; w_enable every 4th cycle; instret_cnt=3 after 12 cycles.
REQ-043 imem_ready low 5 cycles in FETCH -> imem_req/imem_addr held constant 5 cycles; cycle_cnt advances, instret_cnt unchanged.
REQ-044 WB with pc=0x100, je=1 jmp=0x40, be=1 br_off=-8 -> next imem_addr 0x40.
REQ-045 WB with pc=0x10, be=1 br_off=0x6 -> TRAP_EN: trap=1, halted=1, pc=0x10; without: next imem_addr 0x14.
REQ-046 rst low during EXEC, pc=0x20 -> pc=RESET_PC, counters 0, no w_enable pulse; halt=1 in WB -> halted=1, counters frozen.
